// File: rtl/bcp_scheduler_pkg.sv
// Shared widths, result encoding and FSM state type for the BCP clause scheduler.
// The optional statistics helper is only referenced when BCP_SCHED_STATS_EN is defined.
`timescale 1ns/1ps
package bcp_scheduler_pkg;

  localparam int CLAUSE_TABLE_BITS = 6;
  localparam int MAX_CLAUSES_BITS  = 8;
  localparam int MAX_VARS_BITS     = 6;

  // 2'b11 is not a distinct outcome; it behaves exactly like RES_NONE.
  typedef enum logic [1:0] {
    RES_NONE     = 2'b00,
    RES_UNIT     = 2'b01,
    RES_CONFLICT = 2'b10,
    RES_NONE_ALT = 2'b11
  } clause_result_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_PUSH = 2'b10
  } sched_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/bcp_scheduler_if.sv
// Clause-evaluator handshake and imply-stack write port seen by the scheduler.
// master = scheduler side, slave = evaluator / imply stack side.
`timescale 1ns/1ps
interface bcp_scheduler_if;
  import bcp_scheduler_pkg::*;

  logic                         clause_req;
  logic [CLAUSE_TABLE_BITS-1:0] clause_addr;
  logic                         clause_ack;
  logic [1:0]                   clause_result;
  logic [MAX_CLAUSES_BITS-1:0]  clause_id;
  logic [MAX_VARS_BITS-1:0]     unit_var;
  logic                         unit_val;

  logic                         push_imply;
  logic [MAX_VARS_BITS-1:0]     var_in_imply;
  logic                         val_in_imply;
  logic                         full_imply;

  modport master (
    output clause_req, clause_addr, push_imply, var_in_imply, val_in_imply,
    input  clause_ack, clause_result, clause_id, unit_var, unit_val, full_imply
  );

  modport slave (
    input  clause_req, clause_addr, push_imply, var_in_imply, val_in_imply,
    output clause_ack, clause_result, clause_id, unit_var, unit_val, full_imply
  );

endinterface

// File: rtl/bcp_scheduler.sv
// Walks a clause-table address range, pushes implied literals, stops on the first conflict.
// Define BCP_SCHED_STATS_EN to add saturating clause_count / unit_count outputs.
`timescale 1ns/1ps
module bcp_scheduler
  import bcp_scheduler_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         abort,
  input  logic                         start,
  input  logic [CLAUSE_TABLE_BITS-1:0] start_clause,
  input  logic [CLAUSE_TABLE_BITS-1:0] end_clause,
  bcp_scheduler_if.master              bus,
  output logic                         busy,
  output logic                         conflict,
  output logic [MAX_CLAUSES_BITS-1:0]  bcp_clause_idx,
  output logic                         done
`ifdef BCP_SCHED_STATS_EN
  ,
  output logic [15:0]                  clause_count,
  output logic [15:0]                  unit_count
`endif
);

  sched_state_e                 state_q, state_d;
  logic [CLAUSE_TABLE_BITS-1:0] addr_q, addr_d;
  logic [CLAUSE_TABLE_BITS-1:0] end_q, end_d;
  logic                         conflict_q, conflict_d;
  logic [MAX_CLAUSES_BITS-1:0]  idx_q, idx_d;
  logic [MAX_VARS_BITS-1:0]     var_q, var_d;
  logic                         val_q, val_d;
  logic                         done_q, done_d;
  logic                         advance;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      end_q      <= '0;
      conflict_q <= 1'b0;
      idx_q      <= '0;
      var_q      <= '0;
      val_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      end_q      <= end_d;
      conflict_q <= conflict_d;
      idx_q      <= idx_d;
      var_q      <= var_d;
      val_q      <= val_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    end_d      = end_q;
    conflict_d = conflict_q;
    idx_d      = idx_q;
    var_d      = var_q;
    val_d      = val_q;
    done_d     = 1'b0;
    advance    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          end_d      = end_clause;
          addr_d     = start_clause;
          conflict_d = 1'b0;
          idx_d      = '0;
          if (start_clause > end_clause) done_d = 1'b1;
          else                           state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.clause_ack) begin
          case (clause_result_e'(bus.clause_result))
            RES_CONFLICT: begin
              conflict_d = 1'b1;
              idx_d      = bus.clause_id;
              done_d     = 1'b1;
              state_d    = S_IDLE;
            end
            RES_UNIT: begin
              var_d   = bus.unit_var;
              val_d   = bus.unit_val;
              state_d = S_PUSH;
            end
            default: advance = 1'b1;
          endcase
        end
      end
      S_PUSH:  if (!bus.full_imply) advance = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // Compare before incrementing so an all-ones end address terminates instead of wrapping.
    if (advance) begin
      if (addr_q == end_q) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = S_REQ;
      end
    end

    if (abort) begin
      state_d    = S_IDLE;
      addr_d     = '0;
      end_d      = '0;
      conflict_d = 1'b0;
      idx_d      = '0;
      var_d      = '0;
      val_d      = 1'b0;
      done_d     = 1'b0;
    end
  end

  assign bus.clause_req   = (state_q == S_REQ);
  assign bus.clause_addr  = addr_q;
  assign bus.push_imply   = (state_q == S_PUSH) && !bus.full_imply;
  assign bus.var_in_imply = var_q;
  assign bus.val_in_imply = val_q;
  assign busy             = (state_q != S_IDLE) || start;
  assign conflict         = conflict_q;
  assign bcp_clause_idx   = idx_q;
  assign done             = done_q;

`ifdef BCP_SCHED_STATS_EN
  logic [15:0] clause_count_q, clause_count_d;
  logic [15:0] unit_count_q, unit_count_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      clause_count_q <= '0;
      unit_count_q   <= '0;
    end else begin
      clause_count_q <= clause_count_d;
      unit_count_q   <= unit_count_d;
    end
  end

  always_comb begin
    clause_count_d = clause_count_q;
    unit_count_d   = unit_count_q;
    if (abort || (state_q == S_IDLE && start)) begin
      clause_count_d = '0;
      unit_count_d   = '0;
    end else begin
      if (state_q == S_REQ && bus.clause_ack) clause_count_d = sat_inc16(clause_count_q);
      if (bus.push_imply)                     unit_count_d   = sat_inc16(unit_count_q);
    end
  end

  assign clause_count = clause_count_q;
  assign unit_count   = unit_count_q;
`endif

endmodule

// File: tb/tb_bcp_scheduler.sv
// Self-checking bench for bcp_scheduler: a clause-evaluator / imply-stack model drives the bus,
// observed requests and pushes are collected and compared against per-scenario expectations.
`timescale 1ns/1ps
module tb_bcp_scheduler;
  import bcp_scheduler_pkg::*;

  localparam int TABLE_SIZE = 1 << CLAUSE_TABLE_BITS;
  localparam int MAX_CYCLES = 2000;

  logic                         clock = 1'b0;
  logic                         reset;
  logic                         abort;
  logic                         start;
  logic [CLAUSE_TABLE_BITS-1:0] start_clause;
  logic [CLAUSE_TABLE_BITS-1:0] end_clause;
  logic                         busy;
  logic                         conflict;
  logic [MAX_CLAUSES_BITS-1:0]  bcp_clause_idx;
  logic                         done;
`ifdef BCP_SCHED_STATS_EN
  logic [15:0]                  clause_count;
  logic [15:0]                  unit_count;
`endif

  bcp_scheduler_if bus();

  bcp_scheduler dut (
    .clock          (clock),
    .reset          (reset),
    .abort          (abort),
    .start          (start),
    .start_clause   (start_clause),
    .end_clause     (end_clause),
    .bus            (bus),
    .busy           (busy),
    .conflict       (conflict),
    .bcp_clause_idx (bcp_clause_idx),
    .done           (done)
`ifdef BCP_SCHED_STATS_EN
    ,
    .clause_count   (clause_count),
    .unit_count     (unit_count)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Evaluator response table, indexed by clause address
  logic [1:0]                  rsp_res [TABLE_SIZE];
  logic [MAX_CLAUSES_BITS-1:0] rsp_id  [TABLE_SIZE];
  logic [MAX_VARS_BITS-1:0]    rsp_var [TABLE_SIZE];
  logic                        rsp_val [TABLE_SIZE];

  int exp_addr_q[$];
  int obs_addr_q[$];
  int exp_push_q[$];
  int obs_push_q[$];
  int done_cnt, busy_cnt, push_cnt, push_full_cnt, push_wait, addr_moves;
  bit timed_out;

  task automatic clear_table();
    for (int i = 0; i < TABLE_SIZE; i++) begin
      rsp_res[i] = 2'b00;
      rsp_id[i]  = '0;
      rsp_var[i] = '0;
      rsp_val[i] = 1'b0;
    end
    exp_addr_q.delete();
    exp_push_q.delete();
  endtask

  // Drives one start and plays evaluator / imply stack until the DUT goes idle; records what it saw.
  task automatic applyStimulus(input int s, input int e, input int lat, input int full_cyc,
                               input bit abort_on_conflict);
    int  age, full_left, tail, a;
    bit  pending, acked_unit;
    logic [CLAUSE_TABLE_BITS-1:0] req_addr;
    obs_addr_q.delete();
    obs_push_q.delete();
    done_cnt = 0; busy_cnt = 0; push_cnt = 0; push_full_cnt = 0; push_wait = 0; addr_moves = 0;
    timed_out = 1'b0;
    age = 0; full_left = 0; tail = -1; pending = 1'b0; req_addr = '0;
    for (int cyc = 0; cyc < MAX_CYCLES; cyc++) begin
      @(negedge clock);
      start             = (cyc == 0);
      start_clause      = CLAUSE_TABLE_BITS'(s);
      end_clause        = CLAUSE_TABLE_BITS'(e);
      abort             = 1'b0;
      bus.clause_ack    = 1'b0;
      bus.clause_result = 2'b00;
      bus.clause_id     = '0;
      bus.unit_var      = '0;
      bus.unit_val      = 1'b0;
      bus.full_imply    = 1'b0;
      acked_unit        = 1'b0;
      if (pending) begin
        bus.full_imply = (full_left > 0);
        if (full_left > 0) full_left--;
      end
      if (bus.clause_req) begin
        a = int'(bus.clause_addr);
        if (age == 0) begin
          obs_addr_q.push_back(a);
          req_addr = bus.clause_addr;
        end else if (bus.clause_addr !== req_addr) begin
          addr_moves++;
        end
        if (age >= lat) begin
          bus.clause_ack    = 1'b1;
          bus.clause_result = rsp_res[a];
          bus.clause_id     = rsp_id[a];
          bus.unit_var      = rsp_var[a];
          bus.unit_val      = rsp_val[a];
          acked_unit        = (rsp_res[a] == 2'b01);
          if (rsp_res[a] == 2'b10 && abort_on_conflict) abort = 1'b1;
          age = 0;
        end else begin
          age++;
        end
      end
      #1;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (bus.push_imply) begin
        push_cnt++;
        if (bus.full_imply) push_full_cnt++;
        obs_push_q.push_back(int'(bus.var_in_imply) * 2 + int'(bus.val_in_imply));
        pending = 1'b0;
      end else if (pending) begin
        push_wait++;
      end
      if (acked_unit) begin
        pending   = 1'b1;
        full_left = full_cyc;
      end
      if (tail < 0 && cyc > 0 && !busy) tail = 3;
      if (tail == 0) break;
      if (tail > 0) tail--;
    end
    if (tail != 0) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    checks++;
    if ({bus.clause_req, bus.clause_addr, bus.push_imply, bus.var_in_imply, bus.val_in_imply,
         busy, conflict, bcp_clause_idx, done} !== '0)
      begin errors++; $display("[TB] FAIL reset_state: outputs=%0h required=0",
        {bus.clause_req, bus.clause_addr, bus.push_imply, bus.var_in_imply, bus.val_in_imply,
         busy, conflict, bcp_clause_idx, done}); end
    reset = 1'b0;
    @(negedge clock);
    start = 1'b1; start_clause = 6'd0; end_clause = 6'd3;
    @(negedge clock);
    start = 1'b0; #1;
    checks++;
    if ({bus.clause_req, bus.clause_addr} !== {1'b1, 6'd0})
      begin errors++; $display("[TB] FAIL reset_prep_req: req/addr=%0h required=40", {bus.clause_req, bus.clause_addr}); end
    @(negedge clock);
    reset = 1'b1; bus.clause_ack = 1'b1; bus.clause_result = 2'b10; bus.clause_id = 8'd9;
    @(negedge clock);
    reset = 1'b0; bus.clause_ack = 1'b0; bus.clause_result = 2'b00; bus.clause_id = '0; #1;
    checks++;
    if ({busy, bus.clause_req, conflict, done, bcp_clause_idx} !== '0)
      begin errors++; $display("[TB] FAIL reset_midop: busy/req/conf/done/idx=%0h required=0",
        {busy, bus.clause_req, conflict, done, bcp_clause_idx}); end
  endtask

  task automatic test_all_undetermined();
    int ea, oa;
    clear_table();
    for (int i = 0; i <= 3; i++) exp_addr_q.push_back(i);
    applyStimulus(0, 3, 2, 0, 1'b0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL undet_timeout: timed_out=%0d required=0", timed_out); end
    checks++; if (obs_addr_q.size() !== exp_addr_q.size())
      begin errors++; $display("[TB] FAIL undet_req_count: got %0d required %0d", obs_addr_q.size(), exp_addr_q.size()); end
    while (exp_addr_q.size() > 0 && obs_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front(); oa = obs_addr_q.pop_front(); checks++;
      if (oa !== ea) begin errors++; $display("[TB] FAIL undet_addr: got %0d required %0d", oa, ea); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL undet_done: got %0d required 1", done_cnt); end
    checks++; if (conflict !== 1'b0) begin errors++; $display("[TB] FAIL undet_conflict: got %0d required 0", conflict); end
    checks++; if (push_cnt !== 0) begin errors++; $display("[TB] FAIL undet_push: got %0d required 0", push_cnt); end
    checks++; if (addr_moves !== 0) begin errors++; $display("[TB] FAIL undet_addr_stable: moves=%0d required 0", addr_moves); end
  endtask

  task automatic test_unit_push();
    int ea, oa;
    clear_table();
    rsp_res[6] = 2'b01; rsp_var[6] = 6'd9; rsp_val[6] = 1'b1;
    for (int i = 5; i <= 7; i++) exp_addr_q.push_back(i);
    exp_push_q.push_back(9 * 2 + 1);
    applyStimulus(5, 7, 1, 0, 1'b0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL unit_timeout: timed_out=%0d required=0", timed_out); end
    checks++; if (obs_addr_q.size() !== exp_addr_q.size())
      begin errors++; $display("[TB] FAIL unit_req_count: got %0d required %0d", obs_addr_q.size(), exp_addr_q.size()); end
    while (exp_addr_q.size() > 0 && obs_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front(); oa = obs_addr_q.pop_front(); checks++;
      if (oa !== ea) begin errors++; $display("[TB] FAIL unit_addr: got %0d required %0d", oa, ea); end
    end
    checks++; if (push_cnt !== 1) begin errors++; $display("[TB] FAIL unit_push_count: got %0d required 1", push_cnt); end
    while (exp_push_q.size() > 0 && obs_push_q.size() > 0) begin
      ea = exp_push_q.pop_front(); oa = obs_push_q.pop_front(); checks++;
      if (oa !== ea) begin errors++; $display("[TB] FAIL unit_push_data: got var*2+val=%0d required %0d", oa, ea); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL unit_done: got %0d required 1", done_cnt); end
`ifdef BCP_SCHED_STATS_EN
    checks++; if ({clause_count, unit_count} !== {16'd3, 16'd1})
      begin errors++; $display("[TB] FAIL unit_stats: got %0d/%0d required 3/1", clause_count, unit_count); end
`endif
  endtask

  task automatic test_conflict();
    int ea, oa;
    clear_table();
    rsp_res[4] = 2'b10; rsp_id[4] = 8'd17;
    for (int i = 0; i <= 4; i++) exp_addr_q.push_back(i);
    applyStimulus(0, 9, 0, 0, 1'b0);
    checks++; if (obs_addr_q.size() !== exp_addr_q.size())
      begin errors++; $display("[TB] FAIL conf_req_count: got %0d required %0d", obs_addr_q.size(), exp_addr_q.size()); end
    while (exp_addr_q.size() > 0 && obs_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front(); oa = obs_addr_q.pop_front(); checks++;
      if (oa !== ea) begin errors++; $display("[TB] FAIL conf_addr: got %0d required %0d", oa, ea); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL conf_done: got %0d required 1", done_cnt); end
    repeat (5) @(negedge clock);
    #1;
    checks++; if ({conflict, bcp_clause_idx} !== {1'b1, 8'd17})
      begin errors++; $display("[TB] FAIL conf_hold: conflict=%0d idx=%0d required 1/17", conflict, bcp_clause_idx); end
    clear_table();
    applyStimulus(0, 0, 0, 0, 1'b0);
    checks++; if ({conflict, bcp_clause_idx} !== {1'b0, 8'd0})
      begin errors++; $display("[TB] FAIL conf_clear_on_start: conflict=%0d idx=%0d required 0/0", conflict, bcp_clause_idx); end
  endtask

  task automatic test_full_stall();
    int ea, oa;
    clear_table();
    rsp_res[2] = 2'b01; rsp_var[2] = 6'd33; rsp_val[2] = 1'b0;
    exp_push_q.push_back(33 * 2 + 0);
    applyStimulus(2, 2, 0, 3, 1'b0);
    checks++; if (push_wait !== 3) begin errors++; $display("[TB] FAIL full_stall_cycles: got %0d required 3", push_wait); end
    checks++; if (push_full_cnt !== 0) begin errors++; $display("[TB] FAIL full_push_while_full: got %0d required 0", push_full_cnt); end
    checks++; if (push_cnt !== 1) begin errors++; $display("[TB] FAIL full_push_count: got %0d required 1", push_cnt); end
    while (exp_push_q.size() > 0 && obs_push_q.size() > 0) begin
      ea = exp_push_q.pop_front(); oa = obs_push_q.pop_front(); checks++;
      if (oa !== ea) begin errors++; $display("[TB] FAIL full_push_data: got var*2+val=%0d required %0d", oa, ea); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL full_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_empty_range();
    clear_table();
    applyStimulus(8, 2, 0, 0, 1'b0);
    checks++; if (busy_cnt !== 1) begin errors++; $display("[TB] FAIL empty_busy: got %0d cycles required 1", busy_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL empty_done: got %0d required 1", done_cnt); end
    checks++; if (obs_addr_q.size() !== 0) begin errors++; $display("[TB] FAIL empty_no_req: got %0d requests required 0", obs_addr_q.size()); end
  endtask

  task automatic test_end_all_ones();
    int ea, oa;
    clear_table();
    rsp_res[62] = 2'b11;
    exp_addr_q.push_back(62);
    exp_addr_q.push_back(63);
    applyStimulus(62, 63, 1, 0, 1'b0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL wrap_timeout: timed_out=%0d required=0", timed_out); end
    checks++; if (obs_addr_q.size() !== exp_addr_q.size())
      begin errors++; $display("[TB] FAIL wrap_req_count: got %0d required %0d", obs_addr_q.size(), exp_addr_q.size()); end
    while (exp_addr_q.size() > 0 && obs_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front(); oa = obs_addr_q.pop_front(); checks++;
      if (oa !== ea) begin errors++; $display("[TB] FAIL wrap_addr: got %0d required %0d", oa, ea); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL wrap_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_abort_conflict();
    int ea, oa;
    clear_table();
    rsp_res[2] = 2'b10; rsp_id[2] = 8'd5;
    for (int i = 0; i <= 2; i++) exp_addr_q.push_back(i);
    applyStimulus(0, 5, 1, 0, 1'b1);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL abort_timeout: timed_out=%0d required=0", timed_out); end
    while (exp_addr_q.size() > 0 && obs_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front(); oa = obs_addr_q.pop_front(); checks++;
      if (oa !== ea) begin errors++; $display("[TB] FAIL abort_addr: got %0d required %0d", oa, ea); end
    end
    checks++; if (obs_addr_q.size() !== 0) begin errors++; $display("[TB] FAIL abort_extra_req: got %0d extra required 0", obs_addr_q.size()); end
    checks++; if (done_cnt !== 0) begin errors++; $display("[TB] FAIL abort_done: got %0d required 0", done_cnt); end
    checks++; if ({conflict, bcp_clause_idx, busy} !== '0)
      begin errors++; $display("[TB] FAIL abort_state: conflict=%0d idx=%0d busy=%0d required 0/0/0", conflict, bcp_clause_idx, busy); end
`ifdef BCP_SCHED_STATS_EN
    checks++; if ({clause_count, unit_count} !== 32'd0)
      begin errors++; $display("[TB] FAIL abort_stats: got %0d/%0d required 0/0", clause_count, unit_count); end
`endif
  endtask

  initial begin
    reset             = 1'b1;
    abort             = 1'b0;
    start             = 1'b0;
    start_clause      = '0;
    end_clause        = '0;
    bus.clause_ack    = 1'b0;
    bus.clause_result = 2'b00;
    bus.clause_id     = '0;
    bus.unit_var      = '0;
    bus.unit_val      = 1'b0;
    bus.full_imply    = 1'b0;
    clear_table();
    test_reset();
    test_all_undetermined();
    test_unit_push();
    test_conflict();
    test_full_stall();
    test_empty_range();
    test_end_all_ones();
    test_abort_conflict();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
